// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master issues start/mode/operands; the slave returns status and result.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, carry, overflow
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, carry, overflow
  );

endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor.
// One full-add/full-subtract cell plus a carry/borrow flip-flop processes one
// bit per clock, LSB first. A start accepted in IDLE runs WIDTH bit-steps,
// then a single DONE cycle presents the completed result.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_addsub_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Control
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CW-1:0]    cnt_reg;
  logic             accept;
  logic             last_bit;

  // Latched operation and serial datapath
  logic             mode_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] a_sh_next;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] b_sh_next;
  logic [WIDTH-1:0] res_sh_reg;
  logic [WIDTH-1:0] res_sh_next;
  logic             cb_reg;
  logic             cb_next;

  // Bit cell
  logic             ai;
  logic             bi;
  logic             sum_bit;
  logic             c_add;
  logic             c_sub;
  logic             ovf_next;

  // Visible outputs, updated only at the RUN->DONE edge or on reset
  logic [WIDTH-1:0] result_reg;
  logic             carry_reg;
  logic             ovf_reg;

  assign accept   = (state_reg == IDLE) && bus.start;
  assign last_bit = (state_reg == RUN) && (cnt_reg == LAST);

  // Single full-add / full-subtract cell; sum and difference share one XOR.
  assign ai      = a_sh_reg[0];
  assign bi      = b_sh_reg[0];
  assign sum_bit = ai ^ bi ^ cb_reg;
  assign c_add   = (ai & bi) | (ai & cb_reg) | (bi & cb_reg);
  assign c_sub   = (~ai & bi) | (~(ai ^ bi) & cb_reg);
  assign cb_next = mode_reg ? c_sub : c_add;

  // Signed overflow: for add the operand signs must agree, for subtract they
  // must differ; in both cases the result sign departs from operand A's sign.
  // sum_bit is the result MSB on the final bit-step.
  assign ovf_next = (mode_reg ? (a_msb_reg != b_msb_reg)
                              : (a_msb_reg == b_msb_reg))
                    && (sum_bit != a_msb_reg);

  // Right-shift network: operands drain toward bit 0, result fills from the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_sh_next[gi]   = a_sh_reg[gi+1];
      assign b_sh_next[gi]   = b_sh_reg[gi+1];
      assign res_sh_next[gi] = res_sh_reg[gi+1];
    end
  endgenerate
  assign a_sh_next[WIDTH-1]   = 1'b0;
  assign b_sh_next[WIDTH-1]   = 1'b0;
  assign res_sh_next[WIDTH-1] = sum_bit;

  // Next-state logic: IDLE waits for start, RUN counts bits, DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt_reg == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Serial datapath: load operands on accept, then one bit-step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg   <= 1'b0;
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      cb_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      mode_reg   <= bus.mode;
      a_msb_reg  <= bus.a[WIDTH-1];
      b_msb_reg  <= bus.b[WIDTH-1];
      a_sh_reg   <= bus.a;
      b_sh_reg   <= bus.b;
      res_sh_reg <= '0;
      cb_reg     <= 1'b0;
      cnt_reg    <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg   <= a_sh_next;
      b_sh_reg   <= b_sh_next;
      res_sh_reg <= res_sh_next;
      cb_reg     <= cb_next;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

  // Output registers: capture the finished operation on the last bit-step and
  // hold it through the following operation until its own completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else if (last_bit) begin
      result_reg <= res_sh_next;
      carry_reg  <= cb_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign bus.busy     = (state_reg == RUN);
  assign bus.done     = (state_reg == DONE);
  assign bus.result   = result_reg;
  assign bus.carry    = carry_reg;
  assign bus.overflow = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases, mid-run disturbance,
// reset abort, back-to-back throughput and randomized operations, all checked
// against an arithmetic reference model.
module tb_serial_addsub;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Compare one observed value with its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic void ref_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic c, output logic v);
    int ux, uy, sx, sy, full_u, full_s;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
    sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
    full_u = m ? ux - uy : ux + uy;
    full_s = m ? sx - sy : sx + sy;
    r = W'(full_u);
    c = m ? (ux < uy) : (full_u >= (1 << W));
    v = (full_s > (1 << (W - 1)) - 1) || (full_s < -(1 << (W - 1)));
  endfunction

  // One complete operation with latency, busy-length and pulse-width checks.
  task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit disturb, input string tag);
    logic [W-1:0] er;
    logic         ec, ev;
    int           busy_n, wait_n;
    bit           seen;
    ref_op(m, x, y, er, ec, ev);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = 1'($urandom);
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    busy_n = 0;
    seen   = 1'b0;
    for (wait_n = 1; wait_n <= 4 * W; wait_n++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
      if (disturb && wait_n == 3) begin
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(wait_n), 32'(W + 1));
    check({tag, "_busy_len"}, 32'(busy_n), 32'(W));
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'(er));
    check({tag, "_carry"}, 32'(bus.carry), 32'(ec));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(ev));
    $display("op %s mode=%0d a=0x%02h b=0x%02h -> result=0x%02h carry=%0d ovf=%0d",
             tag, m, x, y, bus.result, bus.carry, bus.overflow);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_result_hold"}, 32'(bus.result), 32'(er));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] er;
    logic         ec, ev;
    logic         m_q [6];
    logic [W-1:0] a_q [6];
    logic [W-1:0] b_q [6];
    int           last_done;
    bit           done_leak;
    bit           seen;

    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_carry", 32'(bus.carry), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;

    // Directed cases, with hand-derived expectations alongside the model.
    run_op(1'b0, 8'h3C, 8'h55, 1'b0, "add_3c_55");
    check("add_3c_55_const", 32'({bus.result, bus.carry, bus.overflow}), 32'({8'h91, 1'b0, 1'b1}));
    run_op(1'b1, 8'h10, 8'h20, 1'b0, "sub_10_20");
    check("sub_10_20_const", 32'({bus.result, bus.carry, bus.overflow}), 32'({8'hF0, 1'b1, 1'b0}));
    run_op(1'b0, 8'hFF, 8'h01, 1'b0, "add_ff_01");
    check("add_ff_01_const", 32'({bus.result, bus.carry, bus.overflow}), 32'({8'h00, 1'b1, 1'b0}));
    run_op(1'b1, 8'h80, 8'h01, 1'b0, "sub_80_01");
    check("sub_80_01_const", 32'({bus.result, bus.carry, bus.overflow}), 32'({8'h7F, 1'b0, 1'b1}));
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, "add_7f_01");
    run_op(1'b1, 8'hA5, 8'hA5, 1'b0, "sub_equal");

    // Start pulse with other operands during RUN must be ignored.
    run_op(1'b0, 8'h05, 8'h03, 1'b1, "add_disturbed");
    check("add_disturbed_const", 32'(bus.result), 32'h08);
    for (int i = 0; i < 4; i++) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.mode = 1'($urandom);
      @(negedge clk);
      check("idle_hold_result", 32'(bus.result), 32'h08);
      check("idle_busy", 32'(bus.busy), 32'd0);
    end

    // Reset in the middle of RUN aborts the operation.
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    bus.a     = 8'h5A;
    bus.b     = 8'h33;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_carry", 32'(bus.carry), 32'd0);
    check("abort_ovf", 32'(bus.overflow), 32'd0);
    done_leak = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_leak = 1'b1;
    end
    check("abort_no_done", 32'(done_leak), 32'd0);
    run_op(1'b0, 8'h01, 8'h01, 1'b0, "add_after_rst");
    check("add_after_rst_const", 32'(bus.result), 32'h02);

    // Back-to-back with start held high and alternating mode.
    for (int i = 0; i < 6; i++) begin
      m_q[i] = 1'(i % 2);
      a_q[i] = W'($urandom);
      b_q[i] = W'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m_q[0];
    bus.a     = a_q[0];
    bus.b     = b_q[0];
    last_done = 0;
    for (int i = 0; i < 6; i++) begin
      seen = 1'b0;
      for (int k = 0; k < 4 * W; k++) begin
        if (bus.done) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      ref_op(m_q[i], a_q[i], b_q[i], er, ec, ev);
      check("b2b_done_seen", 32'(seen), 32'd1);
      check("b2b_result", 32'(bus.result), 32'(er));
      check("b2b_carry", 32'(bus.carry), 32'(ec));
      check("b2b_ovf", 32'(bus.overflow), 32'(ev));
      if (i > 0) check("b2b_spacing", 32'(cyc - last_done), 32'(W + 2));
      $display("b2b %0d mode=%0d a=0x%02h b=0x%02h -> result=0x%02h cycle=%0d",
               i, m_q[i], a_q[i], b_q[i], bus.result, cyc);
      last_done = cyc;
      if (i < 5) begin
        bus.mode = m_q[i+1];
        bus.a    = a_q[i+1];
        bus.b    = b_q[i+1];
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      run_op(1'($urandom), W'($urandom), W'($urandom), bit'($urandom_range(0, 3) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
